// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES control register layout, reset value and shadow FSM states
package aes_pkg;

  typedef struct packed {
    logic [23:0] reserved;
    logic        manual_operation;
    logic [2:0]  key_len;
    logic [2:0]  mode;
    logic        operation;
  } ctrl_reg_t;

  localparam ctrl_reg_t CTRL_RESET = '{
    reserved:         24'h0,
    manual_operation: 1'b0,
    key_len:          3'b001,
    mode:             3'b001,
    operation:        1'b0
  };

  typedef enum logic {
    CTRL_SHADOW_EMPTY,
    CTRL_SHADOW_STAGED
  } ctrl_shadow_e;

endpackage

// File: rtl/aes_ctrl_shadow.sv
// rtl/aes_ctrl_shadow.sv - double-write confirmed control register with inverted shadow copy
module aes_ctrl_shadow
  import aes_pkg::*;
#(
  parameter logic [31:0] RESVAL = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  input  logic        re_i,
  input  logic        idle_i,
  output logic [31:0] q_o,
  output logic        qe_o,
  output logic        phase_o,
  output logic        update_err_o,
  output logic        wr_ignored_o,
  output logic        storage_err_o
);

  ctrl_shadow_e state;
  logic [31:0]  q;
  logic [31:0]  q_n;
  logic [31:0]  staged;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= CTRL_SHADOW_EMPTY;
      q             <= RESVAL;
      q_n           <= ~RESVAL;
      staged        <= '0;
      qe_o          <= 1'b0;
      update_err_o  <= 1'b0;
      wr_ignored_o  <= 1'b0;
      storage_err_o <= 1'b0;
    end else begin
      qe_o         <= 1'b0;
      update_err_o <= 1'b0;
      wr_ignored_o <= 1'b0;

      // Sticky until reset; deliberately independent of commits.
      if (q != ~q_n) begin
        storage_err_o <= 1'b1;
      end

      case (state)
        CTRL_SHADOW_EMPTY: begin
          if (we_i) begin
            if (idle_i) begin
              staged <= wd_i;
              state  <= CTRL_SHADOW_STAGED;
            end else begin
              wr_ignored_o <= 1'b1;
            end
          end
        end
        CTRL_SHADOW_STAGED: begin
          // A write always ends the sequence; a read only aborts when no write collides.
          if (we_i) begin
            state <= CTRL_SHADOW_EMPTY;
            if (!idle_i) begin
              wr_ignored_o <= 1'b1;
            end else if (wd_i == staged) begin
              q    <= wd_i;
              q_n  <= ~wd_i;
              qe_o <= 1'b1;
            end else begin
              update_err_o <= 1'b1;
            end
          end else if (re_i) begin
            state <= CTRL_SHADOW_EMPTY;
          end
        end
        default: state <= CTRL_SHADOW_EMPTY;
      endcase
    end
  end

  assign q_o     = q;
  assign phase_o = (state == CTRL_SHADOW_STAGED);

endmodule

// File: tb/tb_aes_ctrl_shadow.sv
// tb/tb_aes_ctrl_shadow.sv - randomized and directed checks of aes_ctrl_shadow against a behavioural model
module tb_aes_ctrl_shadow;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic        re = 1'b0;
  logic        idle = 1'b1;
  logic [31:0] q_o;
  logic        qe_o, phase_o, update_err_o, wr_ignored_o, storage_err_o;

  int n_checks = 0;
  int n_errors = 0;

  aes_ctrl_shadow dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .we_i          (we),
    .wd_i          (wd),
    .re_i          (re),
    .idle_i        (idle),
    .q_o           (q_o),
    .qe_o          (qe_o),
    .phase_o       (phase_o),
    .update_err_o  (update_err_o),
    .wr_ignored_o  (wr_ignored_o),
    .storage_err_o (storage_err_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: a pending value plus a validity flag, outputs as expected after each edge.
  logic        started = 1'b0;
  logic [31:0] m_q = '0;
  logic        m_pending = 1'b0;
  logic [31:0] m_pending_val = '0;
  logic        m_qe = 1'b0, m_uerr = 1'b0, m_wign = 1'b0, m_serr = 1'b0;
  logic        fault_present = 1'b0;
  logic [31:0] force_val;

  always @(posedge clk) begin
    started = 1'b1;
    m_qe = 1'b0;
    m_uerr = 1'b0;
    m_wign = 1'b0;
    if (rst) begin
      m_q = '0;
      m_pending = 1'b0;
      m_serr = 1'b0;
      fault_present = 1'b0;
    end else begin
      if (fault_present) m_serr = 1'b1;
      if (we) begin
        if (!idle) begin
          m_wign = 1'b1;
          m_pending = 1'b0;
        end else if (!m_pending) begin
          m_pending = 1'b1;
          m_pending_val = wd;
        end else begin
          m_pending = 1'b0;
          if (wd == m_pending_val) begin
            m_q = wd;
            m_qe = 1'b1;
            fault_present = 1'b0;
          end else begin
            m_uerr = 1'b1;
          end
        end
      end else if (re) begin
        m_pending = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("q_o", q_o, m_q);
      check("qe_o", {31'b0, qe_o}, {31'b0, m_qe});
      check("phase_o", {31'b0, phase_o}, {31'b0, m_pending});
      check("update_err_o", {31'b0, update_err_o}, {31'b0, m_uerr});
      check("wr_ignored_o", {31'b0, wr_ignored_o}, {31'b0, m_wign});
      check("storage_err_o", {31'b0, storage_err_o}, {31'b0, m_serr});
    end
  end

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic idl);
    @(negedge clk);
    #1;
    we = w;
    wd = d;
    re = r;
    idle = idl;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst q", q_o, 32'h0);
    check("rst phase", {31'b0, phase_o}, 32'h0);
    check("rst flags", {28'b0, qe_o, update_err_o, wr_ignored_o, storage_err_o}, 32'h0);

    step(1'b1, 32'hA5, 1'b0, 1'b1);
    check("commit phase1", {31'b0, phase_o}, 32'h1);
    step(1'b1, 32'hA5, 1'b0, 1'b1);
    check("commit q", q_o, 32'hA5);
    check("commit qe", {31'b0, qe_o}, 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("commit qe width", {31'b0, qe_o}, 32'h0);

    step(1'b1, 32'h1, 1'b0, 1'b1);
    step(1'b1, 32'h2, 1'b0, 1'b1);
    check("mismatch uerr", {31'b0, update_err_o}, 32'h1);
    check("mismatch q", q_o, 32'hA5);
    check("mismatch phase", {31'b0, phase_o}, 32'h0);
    step(1'b1, 32'h2, 1'b0, 1'b1);
    check("mismatch uerr width", {31'b0, update_err_o}, 32'h0);
    step(1'b1, 32'h2, 1'b0, 1'b1);
    check("recommit q", q_o, 32'h2);

    step(1'b1, 32'h5, 1'b0, 1'b0);
    check("busy wign", {31'b0, wr_ignored_o}, 32'h1);
    check("busy phase", {31'b0, phase_o}, 32'h0);
    step(1'b1, 32'h5, 1'b0, 1'b1);
    step(1'b1, 32'h5, 1'b0, 1'b0);
    check("busy staged wign", {31'b0, wr_ignored_o}, 32'h1);
    check("busy staged phase", {31'b0, phase_o}, 32'h0);
    check("busy staged q", q_o, 32'h2);

    step(1'b1, 32'h7, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("abort phase", {31'b0, phase_o}, 32'h0);
    step(1'b1, 32'h7, 1'b0, 1'b1);
    check("restage phase", {31'b0, phase_o}, 32'h1);
    check("restage no qe", {31'b0, qe_o}, 32'h0);
    step(1'b1, 32'h7, 1'b1, 1'b1);
    check("collision q", q_o, 32'h7);
    check("collision qe", {31'b0, qe_o}, 32'h1);

    step(1'b1, 32'h7, 1'b0, 1'b1);
    step(1'b1, 32'h7, 1'b0, 1'b1);
    check("same value qe", {31'b0, qe_o}, 32'h1);

    @(negedge clk);
    #1;
    force_val = ~32'h7 ^ 32'h8;
    force dut.q_n = force_val;
    fault_present = 1'b1;
    @(posedge clk);
    #1;
    check("fault serr", {31'b0, storage_err_o}, 32'h1);
    @(negedge clk);
    #1;
    release dut.q_n;
    step(1'b1, 32'h9, 1'b0, 1'b1);
    step(1'b1, 32'h9, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("fault sticky q", q_o, 32'h9);
    check("fault sticky serr", {31'b0, storage_err_o}, 32'h1);
    do_reset();
    check("fault cleared", {31'b0, storage_err_o}, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [31:0] d;
        case ($urandom_range(0, 3))
          0: d = 32'h0000_0011;
          1: d = 32'h0000_0022;
          2: d = 32'h8000_0011;
          default: d = $urandom;
        endcase
        step($urandom_range(0, 2) != 0, d, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) != 0);
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_ctrl_shadow.md
# aes_ctrl_shadow

Shadowed-write front end for the AES control register. It sits between the register-bus write decode and the committed control value consumed by `aes_core`. A new control word is committed only after two consecutive identical writes while the core is idle. The block also keeps an inverted redundant copy of the committed value, which it checks every cycle for storage faults.

## Interface
Parameters:
- `RESVAL`, default `'0` (`logic [31:0]`): committed value after reset. `aes_core` passes `CTRL_RESET`.

Ports:
- `clk_i` input 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` input 1: synchronous, active-high reset.
- `we_i` input 1: register write strobe, one cycle per bus write.
- `wd_i` input 32: write data, valid with `we_i`.
- `re_i` input 1: register read strobe; aborts a pending first write.
- `idle_i` input 1: core idle. Writes are accepted only while this is high.
- `q_o` output 32: committed control value.
- `qe_o` output 1: one-cycle pulse when `q_o` takes a new value.
- `phase_o` output 1: 1 = first write staged, awaiting confirmation.
- `update_err_o` output 1: one-cycle pulse when the confirming write mismatches.
- `wr_ignored_o` output 1: one-cycle pulse when a write is dropped because `idle_i` = 0.
- `storage_err_o` output 1: sticky; the committed copy and the inverted copy disagree.

## Operation
Internal registers:
- `q` (32), drives `q_o`.
- `q_n` (32), inverted shadow copy.
- `staged` (32).
- FSM, 2 states: `EMPTY`, `STAGED`.

Reset values:
- `q` = `RESVAL`, `q_n` = `~RESVAL`, `staged` = 0.
- State `EMPTY`.
- All pulse outputs 0; `storage_err_o` = 0.

Transitions in `EMPTY`:
- `we_i & idle_i` → `staged` = `wd_i`, go to `STAGED`.
- `we_i & !idle_i` → `wr_ignored_o` pulse, stay in `EMPTY`.
- `re_i` → no effect.

Transitions in `STAGED`:
- `we_i & idle_i & (wd_i == staged)` → `q` = `wd_i`, `q_n` = `~wd_i`, `qe_o` pulse, go to `EMPTY`.
- `we_i & idle_i & (wd_i != staged)` → `update_err_o` pulse, `q` unchanged, go to `EMPTY`. The mismatching data is not restaged.
- `we_i & !idle_i` → `wr_ignored_o` pulse, go to `EMPTY` (staged value discarded).
- `re_i & !we_i` → go to `EMPTY`, no pulses.

Simultaneous events and boundary rules:
- `we_i` and `re_i` in the same cycle: the write is evaluated and the read is ignored.
- Storage check every cycle: if `q != ~q_n`, `storage_err_o` is set and stays set until `rst_i`. This holds in every state and does not block commits.
- Commit of a value equal to the current `q`: still pulses `qe_o`.
- `rst_i` mid-sequence (in `STAGED`): the staged value is lost and the state returns to `EMPTY`. Reset has priority over every other input.

## Timing
- Outputs are registered: every effect of an input in cycle N is visible in cycle N+1.
- `q_o` and `qe_o` change together in cycle N+1 after the confirming write.
- `phase_o` = (state == `STAGED`), registered.
- `update_err_o`, `wr_ignored_o`, `qe_o`: exactly one cycle wide per triggering write.
- `storage_err_o` asserts in the cycle after the corruption is first present.
- Back-to-back writes in consecutive cycles are legal. The minimum commit sequence is 2 cycles.

## Structure
- `aes_pkg` holds `ctrl_reg_t` and `CTRL_RESET`.
- `aes_pkg` also gets the FSM enum `ctrl_shadow_e {CTRL_SHADOW_EMPTY, CTRL_SHADOW_STAGED}`.
- `aes_ctrl_shadow` stays data-type agnostic: `logic [31:0]`. `aes_core` casts `q_o` to `ctrl_reg_t`.
- Single module, no sub-module. The FSM plus three 32-bit registers are small enough to live in one file.

## Test plan
- **Reset:** assert `rst_i` 2 cycles with `RESVAL` = 0 → `q_o` = 0, `phase_o` = 0, all flags 0.
- **Commit:** with `idle_i` = 1, write 0x0000_00A5 twice → `phase_o` = 1 after the first write. One cycle after the second write, `q_o` = 0x0000_00A5 and `qe_o` is high for exactly 1 cycle.
- **Mismatch:** write 0x1 then 0x2 → `update_err_o` pulses once, `q_o` unchanged, `phase_o` = 0. A following pair of 0x2 writes commits 0x2.
- **Busy drop:** `idle_i` = 0, write 0x5 → `wr_ignored_o` pulses, `phase_o` stays 0. From `STAGED` with 0x5, drop `idle_i` and write 0x5 → `wr_ignored_o` pulses, `phase_o` = 0, `q_o` unchanged.
- **Abort and collision:** write 0x7, then `re_i` → `phase_o` = 0; the next 0x7 write restages and does not commit. Separately, `we_i` + `re_i` in the same cycle on the confirming 0x7 → commits 0x7.
- **Storage fault:** force bit 3 of `q_n` → `storage_err_o` = 1 the next cycle. It stays 1 after the force is released and through further commits, and clears only on `rst_i`.
